sine_sweep_ctrl: RTL and testbench

- Sequencer that drives the dual-address sine ROM path with a programmable frequency sweep.
- Accepts one sweep configuration over a valid/ready handshake.
- Runs a phase accumulator whose increment steps from a start value to a stop value, holding each increment for a programmed dwell.
- Each cycle it emits two ROM addresses: phase, and phase plus a fixed offset. The ROM's dout1/dout2 therefore carry a swept sine and a phase-shifted copy.

---
 rtl/sine_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_sine_sweep_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sine_sweep_ctrl.sv
// Frequency-sweep sequencer for the dual-address sine ROM.
// Drives a phase accumulator and emits phase and phase+offset addresses.
module sine_sweep_ctrl #(
  parameter int A_WIDTH     = 8,
  parameter int INC_WIDTH   = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   abort,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [INC_WIDTH-1:0]   cfg_start_inc,
  input  logic [INC_WIDTH-1:0]   cfg_stop_inc,
  input  logic [INC_WIDTH-1:0]   cfg_step,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic [A_WIDTH-1:0]     cfg_offset,
  input  logic                   cfg_loop,
  output logic [A_WIDTH-1:0]     address1,
  output logic [A_WIDTH-1:0]     address2,
  output logic [INC_WIDTH-1:0]   cur_inc,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [INC_WIDTH-1:0]   start_q, stop_q, step_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [A_WIDTH-1:0]     offset_q;
  logic                   loop_q;

  logic [A_WIDTH-1:0]     phase, phase_nxt;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [INC_WIDTH:0]     inc_sum;
  logic                   accept, advance, boundary, over;

  function automatic logic [A_WIDTH-1:0] phase_add(input logic [A_WIDTH-1:0]   p,
                                                   input logic [INC_WIDTH-1:0] inc);
    phase_add = p + A_WIDTH'(inc);
  endfunction

  // A dwell of zero is treated as one cycle per increment.
  function automatic logic [DWELL_WIDTH-1:0] dwell_last(input logic [DWELL_WIDTH-1:0] d);
    dwell_last = (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction

  always_comb begin
    accept    = (state == IDLE) && cfg_valid;
    advance   = (state == RUN) && en && !abort;
    boundary  = advance && (dwell_cnt == dwell_last(dwell_q));
    inc_sum   = {1'b0, cur_inc} + {1'b0, step_q};
    over      = inc_sum > {1'b0, stop_q};
    phase_nxt = phase_add(phase, cur_inc);
    state_nxt = state;
    case (state)
      IDLE: if (cfg_valid) state_nxt = RUN;
      RUN: begin
        if (abort)                           state_nxt = IDLE;
        else if (boundary && over && !loop_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Configuration is pure data; it is only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      start_q  <= cfg_start_inc;
      stop_q   <= cfg_stop_inc;
      step_q   <= cfg_step;
      dwell_q  <= cfg_dwell;
      offset_q <= cfg_offset;
      loop_q   <= cfg_loop;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      address1  <= '0;
      address2  <= '0;
      cur_inc   <= '0;
      dwell_cnt <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_ready <= (state_nxt == IDLE);
      busy      <= (state_nxt == RUN);
      done      <= (state_nxt == DONE);
      if (accept) begin
        phase     <= '0;
        address1  <= '0;
        address2  <= cfg_offset;
        cur_inc   <= cfg_start_inc;
        dwell_cnt <= '0;
      end else if (advance) begin
        phase    <= phase_nxt;
        address1 <= phase_nxt;
        address2 <= phase_nxt + offset_q;
        if (boundary) begin
          dwell_cnt <= '0;
          if (!over)       cur_inc <= inc_sum[INC_WIDTH-1:0];
          else if (loop_q) cur_inc <= start_q;
        end else begin
          dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Scoreboard bench for sine_sweep_ctrl: directed cycles push expected
// outputs tagged with their cycle; a negedge monitor pops and compares.
module tb_sine_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, abort, cfg_valid, cfg_ready, cfg_loop, busy, done;
  logic [7:0]  cfg_start_inc, cfg_stop_inc, cfg_step, cfg_offset;
  logic [15:0] cfg_dwell;
  logic [7:0]  address1, address2, cur_inc;

  sine_sweep_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_offset(cfg_offset),
    .cfg_loop(cfg_loop),
    .address1(address1), .address2(address2), .cur_inc(cur_inc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] a1, a2, ci;
    logic       b, d, r;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (address1 !== e.a1 || address2 !== e.a2 || cur_inc !== e.ci ||
          busy !== e.b || done !== e.d || cfg_ready !== e.r) begin
        n_bad++;
        $display("FAIL %s @cyc%0d: got a1=%0d a2=%0d inc=%0d busy=%b done=%b rdy=%b, want a1=%0d a2=%0d inc=%0d busy=%b done=%b rdy=%b",
                 e.nm, cyc, address1, address2, cur_inc, busy, done, cfg_ready,
                 e.a1, e.a2, e.ci, e.b, e.d, e.r);
      end
    end
  end

  task automatic cfg(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                     input logic [15:0] dw, input logic [7:0] off, input logic lp);
    cfg_start_inc = s; cfg_stop_inc = p; cfg_step = st;
    cfg_dwell = dw; cfg_offset = off; cfg_loop = lp;
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic r, input logic en_i, input logic ab, input logic v,
                      input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] ci,
                      input logic b, input logic d, input logic rdy, input string nm);
    exp_t x;
    rst = r; en = en_i; abort = ab; cfg_valid = v;
    x.cyc = cyc + 1; x.a1 = a1; x.a2 = a2; x.ci = ci;
    x.b = b; x.d = d; x.r = rdy; x.nm = nm;
    sb.push_back(x);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    cfg(8'd0, 8'd0, 8'd0, 16'd0, 8'd0, 1'b0);
    @(negedge clk);

    tick(1, 0, 0, 0,   0,   0, 0, 0, 0, 1, "reset");
    tick(0, 1, 0, 0,   0,   0, 0, 0, 0, 1, "idle_hold");

    // Basic sweep: 1..3 step 1, dwell 2, offset 64
    cfg(8'd1, 8'd3, 8'd1, 16'd2, 8'd64, 1'b0);
    tick(0, 1, 0, 1,   0,  64, 1, 1, 0, 0, "s1_accept");
    tick(0, 1, 0, 0,   1,  65, 1, 1, 0, 0, "s1_e1");
    tick(0, 1, 0, 0,   2,  66, 2, 1, 0, 0, "s1_e2");
    tick(0, 1, 0, 0,   4,  68, 2, 1, 0, 0, "s1_e3");
    tick(0, 1, 0, 0,   6,  70, 3, 1, 0, 0, "s1_e4");
    tick(0, 1, 0, 0,   9,  73, 3, 1, 0, 0, "s1_e5");
    tick(0, 1, 0, 0,  12,  76, 3, 0, 1, 0, "s1_done");
    tick(0, 1, 0, 0,  12,  76, 3, 0, 0, 1, "s1_idle");

    // Same sweep with a 3-cycle stall after address1=4
    tick(0, 1, 0, 1,   0,  64, 1, 1, 0, 0, "st_accept");
    tick(0, 1, 0, 0,   1,  65, 1, 1, 0, 0, "st_e1");
    tick(0, 1, 0, 0,   2,  66, 2, 1, 0, 0, "st_e2");
    tick(0, 1, 0, 0,   4,  68, 2, 1, 0, 0, "st_e3");
    tick(0, 0, 0, 0,   4,  68, 2, 1, 0, 0, "st_hold1");
    tick(0, 0, 0, 0,   4,  68, 2, 1, 0, 0, "st_hold2");
    tick(0, 0, 0, 0,   4,  68, 2, 1, 0, 0, "st_hold3");
    tick(0, 1, 0, 0,   6,  70, 3, 1, 0, 0, "st_e4");
    tick(0, 1, 0, 0,   9,  73, 3, 1, 0, 0, "st_e5");
    tick(0, 1, 0, 0,  12,  76, 3, 0, 1, 0, "st_done");
    tick(0, 1, 0, 0,  12,  76, 3, 0, 0, 1, "st_idle");

    // Phase wrap: inc 200, dwell 3, offset 128
    cfg(8'd200, 8'd200, 8'd1, 16'd3, 8'd128, 1'b0);
    tick(0, 1, 0, 1,   0, 128, 200, 1, 0, 0, "wr_accept");
    tick(0, 1, 0, 0, 200,  72, 200, 1, 0, 0, "wr_e1");
    tick(0, 1, 0, 0, 144,  16, 200, 1, 0, 0, "wr_e2");
    tick(0, 1, 0, 0,  88, 216, 200, 0, 1, 0, "wr_done");
    tick(0, 1, 0, 0,  88, 216, 200, 0, 0, 1, "wr_idle");

    // Looping sweep 1..2, dwell 1, ended by abort
    cfg(8'd1, 8'd2, 8'd1, 16'd1, 8'd10, 1'b1);
    tick(0, 1, 0, 1,   0,  10, 1, 1, 0, 0, "lp_accept");
    tick(0, 1, 0, 0,   1,  11, 2, 1, 0, 0, "lp_e1");
    tick(0, 1, 0, 0,   3,  13, 1, 1, 0, 0, "lp_e2");
    tick(0, 1, 0, 0,   4,  14, 2, 1, 0, 0, "lp_e3");
    tick(0, 1, 0, 0,   6,  16, 1, 1, 0, 0, "lp_e4");
    tick(0, 1, 0, 0,   7,  17, 2, 1, 0, 0, "lp_e5");
    tick(0, 1, 1, 0,   7,  17, 2, 0, 0, 1, "lp_abort");
    tick(0, 1, 1, 0,   7,  17, 2, 0, 0, 1, "lp_abort_idle");

    // cfg_valid held high; dwell 0 acts as dwell 1
    cfg(8'd1, 8'd2, 8'd1, 16'd0, 8'd0, 1'b0);
    tick(0, 1, 0, 1,   0,   0, 1, 1, 0, 0, "hs_accept");
    tick(0, 1, 0, 1,   1,   1, 2, 1, 0, 0, "hs_e1");
    tick(0, 1, 0, 1,   3,   3, 2, 0, 1, 0, "hs_done");
    tick(0, 1, 0, 1,   3,   3, 2, 0, 0, 1, "hs_idle");
    tick(0, 1, 0, 1,   0,   0, 1, 1, 0, 0, "hs_reaccept");
    tick(0, 1, 1, 0,   0,   0, 1, 0, 0, 1, "hs_abort");

    // start > stop finishes at the first boundary
    cfg(8'd5, 8'd3, 8'd1, 16'd2, 8'd0, 1'b0);
    tick(0, 1, 0, 1,   0,   0, 5, 1, 0, 0, "gt_accept");
    tick(0, 1, 0, 0,   5,   5, 5, 1, 0, 0, "gt_e1");
    tick(0, 1, 0, 0,  10,  10, 5, 0, 1, 0, "gt_done");
    tick(0, 1, 0, 0,  10,  10, 5, 0, 0, 1, "gt_idle");

    // Reset in RUN with address1=6
    cfg(8'd1, 8'd3, 8'd1, 16'd2, 8'd64, 1'b0);
    tick(0, 1, 0, 1,   0,  64, 1, 1, 0, 0, "rr_accept");
    tick(0, 1, 0, 0,   1,  65, 1, 1, 0, 0, "rr_e1");
    tick(0, 1, 0, 0,   2,  66, 2, 1, 0, 0, "rr_e2");
    tick(0, 1, 0, 0,   4,  68, 2, 1, 0, 0, "rr_e3");
    tick(0, 1, 0, 0,   6,  70, 3, 1, 0, 0, "rr_e4");
    tick(1, 1, 0, 0,   0,   0, 0, 0, 0, 1, "rr_reset");
    tick(0, 1, 0, 0,   0,   0, 0, 0, 0, 1, "rr_after");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
